// File: rtl/move_scheduler.sv
// move_scheduler: arbitrates key presses, auto-repeat and gravity ticks into a one-deep valid/ready command stream
// Ports: clk, clrn (async active-low reset); left/right/up/down/space key levels; speed selects gravity period;
//   fail holds gravity and flushes non-restart requests; cmd_ready/cmd_valid/cmd command handshake;
//   gravity_miss pulses when a gravity tick finds one already pending.
module move_scheduler #(
  parameter int unsigned GRAVITY_TICKS = 50000000,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_RATE   = 5000000,
  parameter int unsigned CNT_W         = 32
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       left,
  input  logic       right,
  input  logic       up,
  input  logic       down,
  input  logic       space,
  input  logic [1:0] speed,
  input  logic       fail,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd,
  output logic       gravity_miss
);
  localparam int SP = 5, ROT = 4, L = 3, R = 2, DN = 1, GR = 0;
  logic [4:0] keys, prev_q, rise;
  logic [5:0] pend_q, pend_d, set, grant, clr;
  logic cmd_valid_q, cmd_valid_d, miss_q, miss_d, phase_q, phase_d;
  logic [2:0] cmd_q, cmd_d;
  logic [1:0] tgt_q, tgt_d, new_tgt;
  logic [CNT_W-1:0] grav_q, grav_d, rep_q, rep_d, period;
  logic tick, load, held, rep_hit, retarget;
  always_comb begin
    keys = {space, up, left, right, down};
    // only restart may register a new press while the game is over
    rise = keys & ~prev_q & (fail ? 5'b10000 : 5'b11111);
    period = CNT_W'(GRAVITY_TICKS) >> speed;
    tick = ~fail & (grav_q >= period - CNT_W'(1));
    // repeat target: 0 none, 1 left, 2 right, 3 down
    held = tgt_q == 2'd1 ? left : tgt_q == 2'd2 ? right : tgt_q == 2'd3 & down;
    rep_hit = held & (rep_q == (phase_q ? CNT_W'(REPEAT_RATE - 1) : CNT_W'(REPEAT_DELAY - 1)));
    retarget = |rise[2:0];
    new_tgt = rise[2] ? 2'd1 : rise[1] ? 2'd2 : 2'd3;
    set = {rise[4], rise[3], rise[2] | (rep_hit & tgt_q == 2'd1),
           rise[1] | (rep_hit & tgt_q == 2'd2), rise[0] | (rep_hit & tgt_q == 2'd3), tick};
    load = ~cmd_valid_q | cmd_ready;
    grant = ~load ? 6'b0 : pend_q[SP] ? 6'b100000 : pend_q[ROT] ? 6'b010000 : pend_q[L] ? 6'b001000 :
            pend_q[R] ? 6'b000100 : pend_q[DN] ? 6'b000010 : {5'b0, pend_q[GR]};
    // a restart flushes every other request; new events in the same cycle still land
    clr = grant | (grant[SP] ? 6'b011111 : 6'b0);
    pend_d = ((pend_q & ~clr) | set) & (fail ? 6'b100000 : 6'b111111);
    cmd_valid_d = load ? |pend_q : cmd_valid_q;
    cmd_d = ~load ? cmd_q : grant[SP] ? 3'b100 : grant[ROT] ? 3'b111 : grant[L] ? 3'b101 :
            grant[R] ? 3'b110 : {2'b0, grant[DN] | grant[GR]};
    miss_d = tick & pend_q[GR] & ~grant[GR];
    grav_d = (fail | tick | grant[SP]) ? '0 : grav_q + CNT_W'(1);
    tgt_d = retarget ? new_tgt : held ? tgt_q : 2'd0;
    rep_d = (retarget | ~held | grant[SP] | rep_hit) ? '0 : rep_q + CNT_W'(1);
    phase_d = (retarget | ~held | grant[SP]) ? 1'b0 : phase_q | rep_hit;
  end
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      prev_q      <= '0;
      pend_q      <= '0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= '0;
      miss_q      <= 1'b0;
      grav_q      <= '0;
      rep_q       <= '0;
      tgt_q       <= '0;
      phase_q     <= 1'b0;
    end else begin
      prev_q      <= keys;
      pend_q      <= pend_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
      miss_q      <= miss_d;
      grav_q      <= grav_d;
      rep_q       <= rep_d;
      tgt_q       <= tgt_d;
      phase_q     <= phase_d;
    end
  assign cmd_valid    = cmd_valid_q;
  assign cmd          = cmd_q;
  assign gravity_miss = miss_q;
endmodule

// File: tb/tb_move_scheduler.sv
// tb_move_scheduler: directed stimulus with a cycle-stamped scoreboard for move_scheduler
module tb_move_scheduler;
  logic clk = 0, clrn = 0, left = 0, right = 0, up = 0, down = 0, space = 0, fail = 0, cmd_ready = 1;
  logic [1:0] speed = 0;
  logic cmd_valid, gravity_miss;
  logic [2:0] cmd;
  int cyc = 0, checks = 0, errors = 0, gref = 0;
  bit ign_001 = 0;
  typedef struct {logic [2:0] code; int at;} exp_t;
  exp_t sb[$];
  int miss_sb[$];
  move_scheduler #(.GRAVITY_TICKS(16), .REPEAT_DELAY(8), .REPEAT_RATE(4), .CNT_W(32)) dut (
    .clk(clk), .clrn(clrn), .left(left), .right(right), .up(up), .down(down), .space(space),
    .speed(speed), .fail(fail), .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd(cmd),
    .gravity_miss(gravity_miss)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic expect_cmd(input logic [2:0] code, input int at);
    sb.push_back('{code, at});
  endtask
  // two restarts in a row leave the gravity timer at a known phase (gref = second grant edge)
  task automatic resync();
    int c;
    ign_001 = 1;
    c = cyc; space = 1; expect_cmd(3'b100, c + 2); step(1); space = 0; step(4);
    c = cyc; space = 1; expect_cmd(3'b100, c + 2); step(1); space = 0; step(2);
    gref = c + 2;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (clrn && cmd_valid && cmd_ready && !(ign_001 && cmd == 3'b001)) begin
      if (sb.size() == 0) chk("unexpected_cmd", int'(cmd), -1);
      else begin
        e = sb.pop_front();
        chk("cmd_code", int'(cmd), int'(e.code));
        chk("cmd_cycle", cyc, e.at);
      end
    end
    if (gravity_miss) begin
      if (miss_sb.size() == 0) chk("unexpected_miss", cyc, -1);
      else chk("miss_cycle", cyc, miss_sb.pop_front());
    end
  end
  initial begin
    int c, g, s, f, e;
    step(2);
    @(negedge clk);
    chk("rst_valid", int'(cmd_valid), 0);
    chk("rst_cmd", int'(cmd), 0);
    chk("rst_miss", int'(gravity_miss), 0);
    step(1); c = cyc; clrn = 1;
    expect_cmd(3'b001, c + 17); expect_cmd(3'b001, c + 33); expect_cmd(3'b001, c + 49);
    step(16); @(negedge clk);
    chk("idle_valid", int'(cmd_valid), 0);
    step(35);
    chk("gravity_drain", sb.size(), 0);
    ign_001 = 1;
    c = cyc; left = 1; expect_cmd(3'b101, c + 2); step(1); left = 0; step(6);
    c = cyc; left = 1;
    expect_cmd(3'b101, c + 2); expect_cmd(3'b101, c + 10); expect_cmd(3'b101, c + 14);
    expect_cmd(3'b101, c + 18); expect_cmd(3'b101, c + 22);
    step(21); left = 0; step(6);
    chk("repeat_drain", sb.size(), 0);
    resync();
    c = cyc; left = 1; right = 1; up = 1; cmd_ready = 0;
    step(1); left = 0; right = 0; up = 0;
    for (int i = 0; i < 5; i++) begin
      step(1); @(negedge clk);
      chk("stall_valid", int'(cmd_valid), 1);
      chk("stall_cmd", int'(cmd), 7);
    end
    expect_cmd(3'b111, c + 7); expect_cmd(3'b101, c + 8); expect_cmd(3'b110, c + 9);
    step(1); cmd_ready = 1; step(4);
    chk("stall_drain", sb.size(), 0);
    resync(); ign_001 = 0; g = gref; cmd_ready = 0;
    expect_cmd(3'b001, g + 57); expect_cmd(3'b001, g + 58); expect_cmd(3'b001, g + 65);
    miss_sb.push_back(g + 48);
    step(39); @(negedge clk);
    chk("miss_hold_valid", int'(cmd_valid), 1);
    chk("miss_hold_cmd", int'(cmd), 1);
    step(17); cmd_ready = 1; step(10);
    chk("miss_drain", sb.size(), 0);
    chk("miss_pulse_drain", miss_sb.size(), 0);
    resync(); ign_001 = 0; fail = 1;
    step(2); left = 1; up = 1; down = 1; step(1); left = 0; up = 0; down = 0;
    step(20); @(negedge clk);
    chk("fail_quiet", int'(cmd_valid), 0);
    step(1); s = cyc; space = 1; expect_cmd(3'b100, s + 2); step(1); space = 0; step(2);
    fail = 0; f = cyc;
    step(5); space = 1; expect_cmd(3'b100, f + 7); expect_cmd(3'b001, f + 24);
    step(1); space = 0; step(20);
    chk("fail_drain", sb.size(), 0);
    resync(); ign_001 = 0; cmd_ready = 0;
    left = 1; step(1); left = 0; step(1); up = 1; step(1); up = 0; step(2);
    @(negedge clk);
    chk("pre_rst_valid", int'(cmd_valid), 1);
    chk("pre_rst_cmd", int'(cmd), 5);
    #1 clrn = 0;
    #1;
    chk("async_rst_valid", int'(cmd_valid), 0);
    chk("async_rst_cmd", int'(cmd), 0);
    step(1); clrn = 1; cmd_ready = 1; e = cyc;
    expect_cmd(3'b001, e + 17); expect_cmd(3'b001, e + 25); expect_cmd(3'b001, e + 31);
    expect_cmd(3'b001, e + 35); expect_cmd(3'b001, e + 39);
    step(17); speed = 1;
    step(12); speed = 2;
    step(11); cmd_ready = 0; speed = 0;
    @(negedge clk);
    chk("final_drain", sb.size(), 0);
    chk("final_miss_drain", miss_sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
